// File: rtl/exec_seq_pkg.sv
// Shared core types for the execute sequencer and the shared adder.
package exec_seq_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [2:0] {
        ADDER_ADD = 3'd0,
        ADDER_SUB = 3'd1,
        ADDER_EQ  = 3'd2,
        ADDER_NE  = 3'd3,
        ADDER_LT  = 3'd4,
        ADDER_GE  = 3'd5,
        ADDER_LTU = 3'd6,
        ADDER_GEU = 3'd7
    } adderOp_t;

    typedef enum logic [2:0] {
        EK_ADD    = 3'd0,
        EK_SUB    = 3'd1,
        EK_SLT    = 3'd2,
        EK_SLTU   = 3'd3,
        EK_ADDR   = 3'd4,
        EK_BRANCH = 3'd5,
        EK_JAL    = 3'd6,
        EK_JALR   = 3'd7
    } execKind_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EX1  = 2'd1,
        ST_EX2  = 2'd2,
        ST_DONE = 2'd3
    } seqState_t;

    // Latched instruction bundle captured on accept.
    typedef struct packed {
        execKind_t   kind;
        adderOp_t    cond;
        logic        use_imm;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
    } execOp_t;

    // Second ALU operand: immediate or rs2.
    function automatic logic [31:0] op_b(input execOp_t o);
        return o.use_imm ? o.imm : o.rs2;
    endfunction

endpackage

// File: rtl/exec_seq_adder.sv
// Shared 32-bit combinational adder/comparator.
module adder
    import exec_seq_pkg::*;
(
    input  adderOp_t    op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic [31:0] result,
    output logic        cout
);

    logic [32:0] sum;
    logic [32:0] diff;
    logic        eq;
    logic        lt;
    logic        ltu;

    assign sum  = {1'b0, src_a} + {1'b0, src_b};
    assign diff = {1'b0, src_a} + {1'b0, ~src_b} + 33'd1;
    assign eq   = (src_a == src_b);
    assign lt   = ($signed(src_a) < $signed(src_b));
    assign ltu  = ~diff[32];

    // Select arithmetic result or a 0/1 compare flag.
    always_comb begin
        result = '0;
        cout   = 1'b0;
        case (op)
            ADDER_ADD: begin result = sum[31:0];  cout = sum[32];  end
            ADDER_SUB: begin result = diff[31:0]; cout = diff[32]; end
            ADDER_EQ:  result = {31'd0, eq};
            ADDER_NE:  result = {31'd0, ~eq};
            ADDER_LT:  result = {31'd0, lt};
            ADDER_GE:  result = {31'd0, ~lt};
            ADDER_LTU: result = {31'd0, ltu};
            ADDER_GEU: result = {31'd0, ~ltu};
            default:   result = '0;
        endcase
    end

endmodule

// File: rtl/exec_seq.sv
// Multi-cycle execute sequencer driving the single shared adder.
module exec_seq
    import exec_seq_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  execKind_t       in_kind,
    input  adderOp_t        in_cond,
    input  logic            in_use_imm,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    input  logic [XLEN-1:0] in_imm,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_data,
    output logic            out_redirect,
    output logic [XLEN-1:0] out_target
);

    seqState_t   state_q,    state_d;
    execOp_t     op_q,       op_d;
    logic [31:0] data_q,     data_d;
    logic [31:0] target_q,   target_d;
    logic        taken_q,    taken_d;
    logic        redirect_q, redirect_d;

    adderOp_t    add_op;
    logic [31:0] add_a;
    logic [31:0] add_b;
    logic [31:0] add_res;
    logic        adder_cout_unused;

    adder u_adder (
        .op     (add_op),
        .src_a  (add_a),
        .src_b  (add_b),
        .result (add_res),
        .cout   (adder_cout_unused)
    );

    // Adder drive: pure decode of state and latched operands.
    always_comb begin
        add_op = ADDER_ADD;
        add_a  = '0;
        add_b  = '0;
        case (state_q)
            ST_EX1: begin
                case (op_q.kind)
                    EK_ADD, EK_ADDR: begin add_op = ADDER_ADD; add_a = op_q.rs1; add_b = op_b(op_q); end
                    EK_SUB:          begin add_op = ADDER_SUB; add_a = op_q.rs1; add_b = op_b(op_q); end
                    EK_SLT:          begin add_op = ADDER_LT;  add_a = op_q.rs1; add_b = op_b(op_q); end
                    EK_SLTU:         begin add_op = ADDER_LTU; add_a = op_q.rs1; add_b = op_b(op_q); end
                    EK_BRANCH:       begin add_op = op_q.cond; add_a = op_q.rs1; add_b = op_q.rs2;   end
                    default:         begin add_op = ADDER_ADD; add_a = op_q.pc;  add_b = 32'd4;      end
                endcase
            end
            ST_EX2: begin
                add_op = ADDER_ADD;
                add_a  = (op_q.kind == EK_JALR) ? op_q.rs1 : op_q.pc;
                add_b  = op_q.imm;
            end
            default: ;
        endcase
    end

    // Next-state and result-register update.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        data_d     = data_q;
        target_d   = target_q;
        taken_d    = taken_q;
        redirect_d = redirect_q;
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_d.kind    = in_kind;
                        op_d.cond    = in_cond;
                        op_d.use_imm = in_use_imm;
                        op_d.pc      = in_pc;
                        op_d.rs1     = in_rs1;
                        op_d.rs2     = in_rs2;
                        op_d.imm     = in_imm;
                        state_d      = ST_EX1;
                    end
                end
                ST_EX1: begin
                    redirect_d = 1'b0;
                    target_d   = '0;
                    if (op_q.kind == EK_BRANCH) begin
                        data_d  = '0;
                        taken_d = add_res[0];
                        state_d = add_res[0] ? ST_EX2 : ST_DONE;
                    end else begin
                        data_d  = add_res;
                        taken_d = 1'b0;
                        state_d = (op_q.kind == EK_JAL || op_q.kind == EK_JALR) ? ST_EX2 : ST_DONE;
                    end
                end
                ST_EX2: begin
                    // JALR clears bit 0 after the add, so the low bit is dropped here.
                    target_d   = (op_q.kind == EK_JALR) ? {add_res[31:1], 1'b0} : add_res;
                    redirect_d = 1'b1;
                    state_d    = ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            op_q       <= '0;
            data_q     <= '0;
            target_q   <= '0;
            taken_q    <= 1'b0;
            redirect_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            data_q     <= data_d;
            target_q   <= target_d;
            taken_q    <= taken_d;
            redirect_q <= redirect_d;
        end
    end

    assign in_ready     = (state_q == ST_IDLE);
    assign out_valid    = (state_q == ST_DONE);
    assign out_data     = data_q;
    assign out_target   = target_q;
    assign out_redirect = redirect_q;

endmodule

// File: tb/tb_exec_seq.sv
// Scoreboard bench for exec_seq: stimulus pushes expectations, monitor pops on output.
module tb_exec_seq;
    import exec_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    execKind_t   in_kind = EK_ADD;
    adderOp_t    in_cond = ADDER_ADD;
    logic        in_use_imm = 1'b0;
    logic [31:0] in_pc = '0, in_rs1 = '0, in_rs2 = '0, in_imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic        out_redirect;
    logic [31:0] out_target;

    exec_seq #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_kind(in_kind), .in_cond(in_cond), .in_use_imm(in_use_imm),
        .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_redirect(out_redirect), .out_target(out_target)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        red;
        logic [31:0] tgt;
        int unsigned acc;
        int unsigned lat;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned ncyc = 0;
    logic        seen = 1'b0;
    logic        chk_idle = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, ncyc);
        end
    endtask

    // Monitor: compares whenever the DUT presents a result.
    always @(negedge clk) begin
        exp_t e;
        ncyc++;
        if (!rst_n) begin
            seen     = 1'b0;
            chk_idle = 1'b0;
        end else begin
            if (chk_idle) begin
                chk("in_ready_after_xfer", {31'd0, in_ready}, 32'd1);
                chk_idle = 1'b0;
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out_valid", {31'd0, out_valid}, 32'd0);
                end else begin
                    e = exp_q[0];
                    if (!seen) begin
                        chk("latency", ncyc - e.acc, e.lat);
                        seen = 1'b1;
                    end
                    chk("in_ready_in_done", {31'd0, in_ready}, 32'd0);
                    chk("out_data", out_data, e.data);
                    chk("out_redirect", {31'd0, out_redirect}, {31'd0, e.red});
                    if (e.red) chk("out_target", out_target, e.tgt);
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        seen     = 1'b0;
                        chk_idle = 1'b1;
                    end
                end
            end
        end
    end

    task automatic wait_ready();
        int unsigned n = 0;
        @(negedge clk); #1;
        while (!in_ready && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        if (!in_ready) chk("in_ready_timeout", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic issue(input execKind_t k, input adderOp_t c, input logic ui,
                         input logic [31:0] pc, input logic [31:0] rs1,
                         input logic [31:0] rs2, input logic [31:0] imm,
                         input logic push, input logic [31:0] xd,
                         input logic xr, input logic [31:0] xt, input int unsigned lat);
        exp_t e;
        wait_ready();
        in_kind = k; in_cond = c; in_use_imm = ui;
        in_pc = pc; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
        in_valid = 1'b1;
        if (push) begin
            e.data = xd; e.red = xr; e.tgt = xt; e.acc = ncyc; e.lat = lat;
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int unsigned n = 0;
        while ((exp_q.size() != 0 || !in_ready) && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        chk("drain_timeout", exp_q.size(), 32'd0);
    endtask

    initial begin
        int unsigned n;
        #1;
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk); #1;
        chk("post_reset_in_ready", {31'd0, in_ready}, 32'd1);
        chk("post_reset_out_data", out_data, 32'd0);
        chk("post_reset_out_target", out_target, 32'd0);
        chk("post_reset_out_redirect", {31'd0, out_redirect}, 32'd0);

        // Directed vectors with hand-computed results.
        issue(EK_ADD,    ADDER_ADD, 1'b1, 32'h0,        32'd5,        32'd0,        32'hFFFF_FFF9, 1'b1, 32'hFFFF_FFFE, 1'b0, 32'h0,    2);
        issue(EK_SLT,    ADDER_ADD, 1'b0, 32'h0,        32'hFFFF_FFFF, 32'd1,       32'h0,         1'b1, 32'd1,        1'b0, 32'h0,    2);
        issue(EK_SLTU,   ADDER_ADD, 1'b0, 32'h0,        32'hFFFF_FFFF, 32'd1,       32'h0,         1'b1, 32'd0,        1'b0, 32'h0,    2);
        issue(EK_BRANCH, ADDER_GE,  1'b0, 32'h100,      32'd3,        32'd3,        32'hFFFF_FFE0, 1'b1, 32'd0,        1'b1, 32'hE0,   3);
        issue(EK_BRANCH, ADDER_NE,  1'b0, 32'h100,      32'd3,        32'd3,        32'hFFFF_FFE0, 1'b1, 32'd0,        1'b0, 32'h0,    2);
        issue(EK_JALR,   ADDER_ADD, 1'b0, 32'h40,       32'h1001,     32'd0,        32'h2,         1'b1, 32'h44,       1'b1, 32'h1002, 3);
        issue(EK_JAL,    ADDER_ADD, 1'b0, 32'hFFFF_FFFC, 32'd0,       32'd0,        32'h8,         1'b1, 32'h0,        1'b1, 32'h4,    3);
        issue(EK_SUB,    ADDER_ADD, 1'b0, 32'h0,        32'd10,       32'd3,        32'h0,         1'b1, 32'd7,        1'b0, 32'h0,    2);
        issue(EK_ADDR,   ADDER_ADD, 1'b1, 32'h0,        32'h1000,     32'd0,        32'hFFFF_FFFC, 1'b1, 32'hFFC,      1'b0, 32'h0,    2);
        issue(EK_BRANCH, ADDER_LTU, 1'b0, 32'h200,      32'd1,        32'hFFFF_FFFF, 32'h10,       1'b1, 32'd0,        1'b1, 32'h210,  3);
        drain();

        // Backpressure: out_ready low for five DONE cycles.
        @(posedge clk); #1 out_ready = 1'b0;
        issue(EK_ADD, ADDER_ADD, 1'b0, 32'h0, 32'h1234, 32'h1111, 32'h0, 1'b1, 32'h2345, 1'b0, 32'h0, 2);
        n = 0;
        @(negedge clk); #1;
        while (!out_valid && n < 20) begin @(negedge clk); #1; n++; end
        chk("bp_out_valid_seen", {31'd0, out_valid}, 32'd1);
        repeat (4) @(negedge clk);
        @(posedge clk); #1 out_ready = 1'b1;
        drain();

        // Flush during EX2 of a JAL: no result, back to IDLE.
        issue(EK_JAL, ADDER_ADD, 1'b0, 32'h300, 32'd0, 32'd0, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 0);
        @(negedge clk);
        @(negedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk); #1;
        chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
        chk("flush_out_valid", {31'd0, out_valid}, 32'd0);

        // Flush coinciding with in_valid in IDLE: nothing accepted.
        in_kind = EK_ADD; in_rs1 = 32'd1; in_rs2 = 32'd1; in_use_imm = 1'b0;
        in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        @(negedge clk); #1;
        chk("flush_idle_no_accept", {31'd0, in_ready}, 32'd1);
        repeat (3) @(negedge clk);

        // Reset pulse during EX1 of an op after a nonzero result.
        issue(EK_ADD, ADDER_ADD, 1'b0, 32'h0, 32'h55, 32'h22, 32'h0, 1'b1, 32'h77, 1'b0, 32'h0, 2);
        drain();
        issue(EK_SUB, ADDER_ADD, 1'b0, 32'h0, 32'h9, 32'h1, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 0);
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("rst_async_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_async_out_data", out_data, 32'd0);
        @(negedge clk); #1 rst_n = 1'b1;
        @(negedge clk); #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_target", out_target, 32'd0);
        chk("rst_out_redirect", {31'd0, out_redirect}, 32'd0);
        repeat (4) @(negedge clk);

        // Post-reset operation still works.
        issue(EK_JALR, ADDER_ADD, 1'b0, 32'h80, 32'h2000, 32'd0, 32'h7, 1'b1, 32'h84, 1'b1, 32'h2006, 3);
        drain();
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time guard.
    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/exec_seq.md
# exec_seq

Multi-cycle execute sequencer sitting directly upstream of the shared `adder`. It accepts one decoded integer/control instruction per handshake and drives the single adder over one or two cycles: compare, then target, or link, then target. It registers the results and presents them to writeback/fetch through a valid/ready handshake. All adds, compares, address calculations and branch targets in the core go through this block's one `adder` instance.

## Interface
- `XLEN`, 32, datapath width; only 32 is supported because `adder` is fixed at 32 bits.
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `flush`  in  1  synchronous abort of the in-flight operation.
- `in_valid`  in  1  decoded instruction available.
- `in_ready`  out  1  sequencer can accept.
- `in_kind`  in  execKind_t  one of EK_ADD, EK_SUB, EK_SLT, EK_SLTU, EK_ADDR, EK_BRANCH, EK_JAL, EK_JALR.
- `in_cond`  in  adderOp_t  branch condition (ADDER_EQ/NE/LT/GE/LTU/GEU); used only for EK_BRANCH.
- `in_use_imm`  in  1  second operand is `in_imm` instead of `in_rs2` (ALU/ADDR kinds).
- `in_pc`, `in_rs1`, `in_rs2`, `in_imm`  in  XLEN each  operands; imm already sign-extended.
- `out_valid`  out  1  result held.
- `out_ready`  in  1  consumer takes result.
- `out_data`  out  XLEN  ALU result, effective address, or link value (pc+4).
- `out_redirect`  out  1  taken branch or jump.
- `out_target`  out  XLEN  redirect PC; meaningful only when `out_redirect`=1.

## Operation
- States: IDLE, EX1, EX2, DONE. `in_ready` = (state==IDLE). On accept, latch all `in_*` and go to EX1.
- EX1 by kind; the adder result is registered at the end of EX1:
  - EK_ADD/EK_ADDR: ADDER_ADD(rs1, opB), where opB = use_imm ? imm : rs2. Result goes to data. Next state DONE.
  - EK_SUB: ADDER_SUB(rs1, opB). Result goes to data. Next state DONE.
  - EK_SLT/EK_SLTU: ADDER_LT/LTU(rs1, opB). Result goes to data (0/1). Next state DONE.
  - EK_BRANCH: in_cond(rs1, rs2). Bit 0 goes to taken, and data←0. If taken, go to EX2; otherwise go to DONE with redirect=0.
  - EK_JAL/EK_JALR: ADDER_ADD(pc, 4). Result goes to data (link). Next state EX2.
- EX2, on the target adder pass:
  - EK_BRANCH/EK_JAL: target←ADDER_ADD(pc, imm).
  - EK_JALR: target←ADDER_ADD(rs1, imm) & ~1.
  - In all EX2 cases redirect←1 and the next state is DONE.
- DONE: `out_valid`=1. Outputs stay stable until `out_ready`, then go to IDLE. No new accept in the same cycle.
- Arithmetic wraps modulo 2^32 (e.g. pc=0xFFFFFFFC, jal link=0x00000000). The JALR bit-0 clear is applied after the add.
- `flush` in any state: go to IDLE next cycle, deassert `out_valid`, and discard the operation. If `flush` and `in_valid` coincide in IDLE, nothing is accepted.
- Reset (async, any state): state=IDLE, `out_valid`=0, `out_redirect`=0, `out_data`=0, `out_target`=0, internal taken=0. `in_ready`=1 the first cycle after release.

## Timing
- Accept at edge T. EX1 in cycle T+1. Single-pass kinds and not-taken branches have `out_valid` from T+2. Taken branches and jumps have `out_valid` from T+3.
- Adder drive (`op`, `src_a`, `src_b`) is a pure decode of state plus latched operands. The adder is combinational within EX1/EX2, so its path is the block's critical path.
- Max throughput is one instruction per 3 cycles (single-pass) or 4 cycles (two-pass) with `out_ready` tied high.
- `out_*` are registered and never change while `out_valid`=1 and `out_ready`=0.

## Structure
- Shared core package holds `adderOp_t` (existing) and the new `execKind_t` enum. Both use explicit encodings so bench and RTL agree.
- One sub-module: an instance of `adder`, with op/src_a/src_b driven by a combinational mux from this block. The adder's `cout` is unused.
- Registers: state, latched operand bundle, data, target, taken, redirect.

## Test plan
- EK_ADD, rs1=5, imm=-7, use_imm=1 → out_data=0xFFFFFFFE, redirect=0, out_valid at T+2.
- EK_SLT rs1=0xFFFFFFFF, rs2=1 → data=1; EK_SLTU with the same operands → data=0.
- EK_BRANCH ADDER_GE, rs1=3, rs2=3, pc=0x100, imm=-0x20 → redirect=1, target=0xE0, valid at T+3. Repeat with ADDER_NE → redirect=0, valid at T+2.
- EK_JALR rs1=0x1001, imm=0x2, pc=0x40 → data=0x44, target=0x1002. EK_JAL pc=0xFFFFFFFC, imm=8 → data=0, target=4.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → outputs stable, in_ready=0. Release → one transfer, then in_ready=1 next cycle.
- Flush during EX2 of a JAL, and rst_n pulse during EX1 → no out_valid, IDLE next cycle. After reset all outputs are 0 and in_ready=1.
